// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix scanner and the row-register side.
// Holds the scan state encoding, matrix geometry and the pixel index helper.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int MATRIX_ROWS = 5;
    localparam int MATRIX_COLS = 7;

    // Flat bit position of a pixel; line-major, matching the frame_in packing.
    function automatic int pix_idx(input int row, input int col);
        return row * MATRIX_COLS + col;
    endfunction

    // Counter width able to hold the larger of the two phase lengths minus one.
    function automatic int cnt_width(input int div, input int blank);
        int m;
        m = (div > blank) ? div : blank;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Pixel image in, row/column drive out, between row registers and the matrix driver.
// Optional LED_MATRIX_SCANNER_DIM_EN adds the 2-bit brightness input.
interface led_matrix_scanner_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS = MATRIX_ROWS,
    parameter int COLS = MATRIX_COLS
);
    logic [ROWS*COLS-1:0] frame_in;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_n;
    logic                 frame_start;
`ifdef LED_MATRIX_SCANNER_DIM_EN
    logic [1:0]           bright;

    modport master (input frame_in, input bright, output row_sel, output col_n, output frame_start);
    modport slave  (output frame_in, output bright, input row_sel, input col_n, input frame_start);
`else
    modport master (input frame_in, output row_sel, output col_n, output frame_start);
    modport slave  (output frame_in, input row_sel, input col_n, input frame_start);
`endif
endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// Phase timer: counts up to a loadable terminal value, flags it, then restarts at zero.
module scan_timer
    import led_matrix_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clear,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = (cnt == term);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST || clear || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed 5x7 matrix driver: LOAD a frame, then BLANK/DRIVE each line in turn.
// Define LED_MATRIX_SCANNER_DIM_EN for per-frame brightness (on-time within DRIVE).
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = MATRIX_ROWS,
    parameter int COLS         = MATRIX_COLS,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    led_matrix_scanner_if.master bus
);
    localparam int CNT_W = cnt_width(DIV, BLANK_CYCLES);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] DRIVE_TERM = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

    scan_state_t          state, state_nxt;
    logic [ROW_W-1:0]     row_idx, row_idx_nxt;
    logic [ROWS*COLS-1:0] shadow;
    logic [CNT_W-1:0]     cnt, term;
    logic                 tc;
    logic                 pix_on;

    assign term = (state == DRIVE) ? DRIVE_TERM : BLANK_TERM;

    scan_timer #(.W(CNT_W)) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .clear (state == LOAD),
        .term  (term),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Shadow is only written in LOAD, so a new image never tears the frame on display.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= LOAD;
            row_idx <= '0;
            shadow  <= '0;
        end else begin
            state   <= state_nxt;
            row_idx <= row_idx_nxt;
            if (state == LOAD) begin
                shadow <= bus.frame_in;
            end
        end
    end

`ifdef LED_MATRIX_SCANNER_DIM_EN
    logic [1:0]  bright_q;
    logic [31:0] on_lim;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bright_q <= 2'd3;
        end else if (state == LOAD) begin
            bright_q <= bus.bright;
        end
    end

    assign on_lim = ((32'(bright_q) + 32'd1) * 32'(DIV)) >> 2;
    assign pix_on = (32'(cnt) < on_lim);
`else
    assign pix_on = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        unique case (state)
            LOAD: begin
                row_idx_nxt = '0;
                state_nxt   = BLANK;
            end
            BLANK: begin
                if (tc) state_nxt = DRIVE;
            end
            DRIVE: begin
                if (tc) begin
                    if (row_idx == LAST_ROW) begin
                        state_nxt = LOAD;
                    end else begin
                        row_idx_nxt = row_idx + 1'b1;
                        state_nxt   = BLANK;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Outputs decode straight from state; RST forces them off while it is held.
    always_comb begin
        bus.row_sel     = '0;
        bus.col_n       = '1;
        bus.frame_start = 1'b0;
        if (!RST) begin
            if (state == LOAD) begin
                bus.frame_start = 1'b1;
            end else if (state == DRIVE) begin
                bus.row_sel = ROWS'(1) << row_idx;
                if (pix_on) begin
                    bus.col_n = ~shadow[int'(row_idx)*COLS +: COLS];
                end
            end
        end
    end
endmodule
